// File: rtl/hex_writer_pkg.sv
// Shared types and constants for the Avalon HEX display writer.
// Holds the FSM state enum, the 7-segment LUT and fixed bus constants.
package hex_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_WAIT_RD,
        ST_FINISH
    } state_t;

    // Active-high segment patterns, seg[0]=a .. seg[6]=g.
    // Index 15 is listed first so that SEG_LUT[n] gives digit n.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Active-high pattern for a blanked digit
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] AVM_BYTEENABLE = 4'hF;

endpackage

// File: rtl/hex_seg_encoder.sv
// Combinational nibble to 7-segment encoder with blanking and polarity.
// Ports: i_nibble (hex digit), i_blank (force off), o_seg (seg[6:0]=g..a).
module hex_seg_encoder
    import hex_writer_pkg::*;
#(
    parameter bit ACTIVE_LOW_SEG = 1'b1
) (
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    logic [6:0] w_seg_hi;

    assign w_seg_hi = i_blank ? SEG_BLANK : SEG_LUT[i_nibble];
    // Inverting also turns the blank pattern into all-ones
    assign o_seg    = ACTIVE_LOW_SEG ? ~w_seg_hi : w_seg_hi;

endmodule

// File: rtl/avalon_hex_writer.sv
// Avalon-MM master writing four encoded hex digits to a PIO data register,
// with optional read-back verify and bounded retry.
// Ports: clk/reset_n; in_valid/in_ready/in_value/in_blank request stream;
// avm_* Avalon-MM master; done/error one-cycle completion pulses.
module avalon_hex_writer
    import hex_writer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter bit          ACTIVE_LOW_SEG = 1'b1,
    parameter bit          VERIFY         = 1'b1,
    parameter int          MAX_RETRY      = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_value,
    input  logic [3:0]  in_blank,
    output logic [31:0] avm_address,
    output logic        avm_write,
    output logic        avm_read,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        done,
    output logic        error
);

    localparam logic [2:0] LP_MAX_RETRY = 3'(MAX_RETRY);

    state_t      r_state;
    logic        r_ready;
    logic        r_write;
    logic        r_read;
    logic [31:0] r_wdata;
    logic        r_done;
    logic        r_error;
    logic [2:0]  r_retry;

    logic [3:0][6:0] w_seg;
    logic [31:0]     w_word;

    for (genvar g = 0; g < 4; g++) begin : g_enc
        hex_seg_encoder #(
            .ACTIVE_LOW_SEG(ACTIVE_LOW_SEG)
        ) u_enc (
            .i_nibble(in_value[4*g +: 4]),
            .i_blank (in_blank[g]),
            .o_seg   (w_seg[g])
        );
    end

    // Bit 7 of every byte is the unused decimal point, held at 0
    assign w_word = {1'b0, w_seg[3], 1'b0, w_seg[2],
                     1'b0, w_seg[1], 1'b0, w_seg[0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_write <= 1'b0;
            r_read  <= 1'b0;
            r_wdata <= '0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_retry <= '0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    // r_ready is the registered form of state==IDLE,
                    // held low for the first cycle after reset release
                    if (in_valid && r_ready) begin
                        r_wdata <= w_word;
                        r_write <= 1'b1;
                        r_ready <= 1'b0;
                        r_state <= ST_WRITE;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (!avm_waitrequest) begin
                        r_write <= 1'b0;
                        if (VERIFY) begin
                            r_read  <= 1'b1;
                            r_state <= ST_READ;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= ST_FINISH;
                        end
                    end
                end
                ST_READ: begin
                    if (!avm_waitrequest) begin
                        r_read  <= 1'b0;
                        r_state <= ST_WAIT_RD;
                    end
                end
                ST_WAIT_RD: begin
                    if (avm_readdatavalid) begin
                        if (avm_readdata == r_wdata) begin
                            r_done  <= 1'b1;
                            r_state <= ST_FINISH;
                        end else if (r_retry < LP_MAX_RETRY) begin
                            r_retry <= r_retry + 3'd1;
                            r_write <= 1'b1;
                            r_state <= ST_WRITE;
                        end else begin
                            r_done  <= 1'b1;
                            r_error <= 1'b1;
                            r_state <= ST_FINISH;
                        end
                    end
                end
                ST_FINISH: begin
                    r_retry <= '0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready       = r_ready;
    assign avm_address    = BASE_ADDR;
    assign avm_write      = r_write;
    assign avm_read       = r_read;
    assign avm_writedata  = r_wdata;
    assign avm_byteenable = AVM_BYTEENABLE;
    assign done           = r_done;
    assign error          = r_error;

endmodule

// File: tb/tb_avalon_hex_writer.sv
// Directed testbench for avalon_hex_writer.
// Two instances: active-low write-only, and active-high with verify.
module tb_avalon_hex_writer;

    logic clk;
    logic reset_n;

    int n_checks;
    int n_fail;

    // Instance 0: ACTIVE_LOW_SEG=1, VERIFY=0
    logic        v0;
    logic        rdy0;
    logic [15:0] val0;
    logic [3:0]  blk0;
    logic [31:0] addr0;
    logic        wr0;
    logic        rd0;
    logic [31:0] wd0;
    logic [3:0]  be0;
    logic        wait0;
    logic [31:0] rdat0;
    logic        rdv0;
    logic        done0;
    logic        err0;

    // Instance 1: ACTIVE_LOW_SEG=0, VERIFY=1, MAX_RETRY=2
    logic        v1;
    logic        rdy1;
    logic [15:0] val1;
    logic [3:0]  blk1;
    logic [31:0] addr1;
    logic        wr1;
    logic        rd1;
    logic [31:0] wd1;
    logic [3:0]  be1;
    logic        wait1;
    logic [31:0] rdat1;
    logic        rdv1;
    logic        done1;
    logic        err1;

    // Slave model controls for instance 1
    bit          s1_echo;
    int          s1_lat;
    int          s1_cnt;
    logic [31:0] s1_mem;
    int          s1_writes;
    int          s1_reads;
    int          done1_cnt;

    avalon_hex_writer #(
        .BASE_ADDR     (32'h0000_0000),
        .ACTIVE_LOW_SEG(1'b1),
        .VERIFY        (1'b0),
        .MAX_RETRY     (2)
    ) dut0 (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_valid         (v0),
        .in_ready         (rdy0),
        .in_value         (val0),
        .in_blank         (blk0),
        .avm_address      (addr0),
        .avm_write        (wr0),
        .avm_read         (rd0),
        .avm_writedata    (wd0),
        .avm_byteenable   (be0),
        .avm_waitrequest  (wait0),
        .avm_readdata     (rdat0),
        .avm_readdatavalid(rdv0),
        .done             (done0),
        .error            (err0)
    );

    avalon_hex_writer #(
        .BASE_ADDR     (32'h0000_0040),
        .ACTIVE_LOW_SEG(1'b0),
        .VERIFY        (1'b1),
        .MAX_RETRY     (2)
    ) dut1 (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_valid         (v1),
        .in_ready         (rdy1),
        .in_value         (val1),
        .in_blank         (blk1),
        .avm_address      (addr1),
        .avm_write        (wr1),
        .avm_read         (rd1),
        .avm_writedata    (wd1),
        .avm_byteenable   (be1),
        .avm_waitrequest  (wait1),
        .avm_readdata     (rdat1),
        .avm_readdatavalid(rdv1),
        .done             (done1),
        .error            (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave for instance 1: decides inputs on the falling edge
    always @(negedge clk) begin
        rdv1  = 1'b0;
        rdat1 = 32'h0;
        if (s1_cnt > 0) begin
            s1_cnt = s1_cnt - 1;
            if (s1_cnt == 0) begin
                rdv1  = 1'b1;
                rdat1 = s1_echo ? s1_mem : 32'h0;
            end
        end
        if (wr1 && !wait1) begin
            s1_mem    = wd1;
            s1_writes = s1_writes + 1;
        end
        if (rd1 && !wait1) begin
            s1_cnt   = s1_lat;
            s1_reads = s1_reads + 1;
        end
    end

    always @(posedge clk) begin
        if (done1) done1_cnt <= done1_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on instance 1; returns at the post-handshake sample
    task automatic req1(input logic [15:0] v, input logic [3:0] b);
        val1 = v;
        blk1 = b;
        v1   = 1'b1;
        step();
        v1   = 1'b0;
    endtask

    // Counts samples after the handshake until done1 is seen, bounded
    task automatic wait_done1(output int cyc);
        cyc = 0;
        while (!done1 && cyc < 60) begin
            step();
            cyc++;
        end
        chk("done1_seen", {31'b0, done1}, 32'h1);
    endtask

    initial begin
        int cyc;
        int dc;
        n_checks  = 0;
        n_fail    = 0;
        v0 = 0; val0 = 0; blk0 = 0; wait0 = 0; rdat0 = 0; rdv0 = 0;
        v1 = 0; val1 = 0; blk1 = 0; wait1 = 0; rdat1 = 0; rdv1 = 0;
        s1_echo = 1; s1_lat = 1; s1_cnt = 0; s1_mem = 0;
        s1_writes = 0; s1_reads = 0; done1_cnt = 0;
        reset_n = 1'b0;

        // Reset state
        #12;
        chk("rst_ready", {31'b0, rdy0}, 32'h0);
        chk("rst_write", {31'b0, wr0}, 32'h0);
        chk("rst_wdata", wd0, 32'h0);
        chk("rst_done", {31'b0, done0}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("ready_after_rst", {31'b0, rdy0}, 32'h1);
        chk("ready1_after_rst", {31'b0, rdy1}, 32'h1);

        // Active-low, write only, 16'h1234
        val0 = 16'h1234; blk0 = 4'h0; v0 = 1'b1;
        step();
        v0 = 1'b0;
        chk("t1_write", {31'b0, wr0}, 32'h1);
        chk("t1_read", {31'b0, rd0}, 32'h0);
        chk("t1_wdata", wd0, 32'h7924_3019);
        chk("t1_be", {28'b0, be0}, 32'hF);
        chk("t1_addr", addr0, 32'h0);
        chk("t1_ready", {31'b0, rdy0}, 32'h0);
        chk("t1_done_early", {31'b0, done0}, 32'h0);
        step();
        chk("t1_done", {31'b0, done0}, 32'h1);
        chk("t1_err", {31'b0, err0}, 32'h0);
        chk("t1_write_off", {31'b0, wr0}, 32'h0);
        step();
        chk("t1_done_pulse", {31'b0, done0}, 32'h0);
        chk("t1_ready_back", {31'b0, rdy0}, 32'h1);
        chk("t1_wdata_hold", wd0, 32'h7924_3019);

        // Waitrequest stall: 16'hABCD active-low
        val0 = 16'hABCD; blk0 = 4'h0; v0 = 1'b1; wait0 = 1'b1;
        step();
        val0 = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            chk("t3_write", {31'b0, wr0}, 32'h1);
            chk("t3_wdata", wd0, 32'h0803_4621);
            chk("t3_ready", {31'b0, rdy0}, 32'h0);
            chk("t3_nodone", {31'b0, done0}, 32'h0);
            if (i < 5) step();
        end
        wait0 = 1'b0;
        v0 = 1'b0;
        step();
        chk("t3_done", {31'b0, done0}, 32'h1);
        chk("t3_wdata_end", wd0, 32'h0803_4621);
        step();

        // Active-high with blank digit 3, verify, latency 1
        s1_echo = 1; s1_lat = 1;
        req1(16'h1234, 4'b1000);
        chk("t2_wdata", wd1, 32'h005B_4F66);
        chk("t2_addr", addr1, 32'h0000_0040);
        chk("t2_w", {30'b0, wr1, rd1}, 32'h2);
        step();
        chk("t2_r", {30'b0, wr1, rd1}, 32'h1);
        step();
        chk("t2_idle_bus", {30'b0, wr1, rd1}, 32'h0);
        chk("t2_nodone", {31'b0, done1}, 32'h0);
        step();
        chk("t2_done", {31'b0, done1}, 32'h1);
        chk("t2_err", {31'b0, err1}, 32'h0);
        step();
        step();

        // Verify with read latency 3
        s1_lat = 3;
        req1(16'h90AF, 4'b0000);
        chk("t4_wdata", wd1, 32'h6F3F_7771);
        wait_done1(cyc);
        chk("t4_cycles", cyc, 32'd5);
        chk("t4_err", {31'b0, err1}, 32'h0);
        step();
        step();

        // Slave always returns zero: 3 attempts then error
        s1_echo = 0; s1_lat = 1; s1_writes = 0; s1_reads = 0;
        req1(16'h5678, 4'b0000);
        chk("t5_wdata", wd1, 32'h6D7D_077F);
        wait_done1(cyc);
        chk("t5_cycles", cyc, 32'd9);
        chk("t5_err", {31'b0, err1}, 32'h1);
        chk("t5_writes", s1_writes, 32'd3);
        chk("t5_reads", s1_reads, 32'd3);
        step();
        chk("t5_err_pulse", {30'b0, done1, err1}, 32'h0);
        step();

        // Reset in READ state
        s1_echo = 1; s1_lat = 1;
        req1(16'h1234, 4'b0000);
        step();
        chk("t6_in_read", {31'b0, rd1}, 32'h1);
        dc = done1_cnt;
        reset_n = 1'b0;
        #1;
        chk("t6_read_drop", {31'b0, rd1}, 32'h0);
        chk("t6_write_drop", {31'b0, wr1}, 32'h0);
        chk("t6_ready_low", {31'b0, rdy1}, 32'h0);
        step();
        step();
        reset_n = 1'b1;
        step();
        step();
        chk("t6_no_done", done1_cnt, dc);
        chk("t6_ready", {31'b0, rdy1}, 32'h1);
        req1(16'hFFFF, 4'b0000);
        chk("t6_wdata", wd1, 32'h7171_7171);
        wait_done1(cyc);
        chk("t6_cycles", cyc, 32'd3);
        chk("t6_err", {31'b0, err1}, 32'h0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Never assert write and read together
    always @(negedge clk) begin
        if (reset_n && wr1 && rd1) begin
            n_fail++;
            $display("FAIL rw_overlap: got 1 expected 0");
        end
    end

endmodule
